// File: rtl/demo_fm_loader_if.sv
// AXI4-Stream read channel from the DMA (MM2S) into the feature-map loader.
interface demo_fm_loader_if #(
  parameter int unsigned DATA_W = 64
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  // DMA side drives the beat, loader returns the accept.
  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/demo_fm_loader.sv
// Feature-map loader: streams DMA beats into per-column byte-wide FM buffers.
// Byte lane k of each beat goes to PE column k; all columns share the beat address.
module demo_fm_loader #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned PE_COL   = DATA_W / 8,
  parameter int unsigned FM_DEPTH = 512,
  localparam int unsigned AW      = $clog2(FM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AW:0]          start_len,
  input  logic                 start_pp,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  demo_fm_loader_if.slave      m_axis_mm2s,
  output logic [AW*PE_COL-1:0] load_fm_wr_addr,
  output logic [8*PE_COL-1:0]  load_fm_din,
  output logic [PE_COL-1:0]    load_fm_wr_en,
  output logic [PE_COL-1:0]    load_fm_ping_pong
);

  localparam logic [AW:0] DepthLen = (AW + 1)'(FM_DEPTH);
  localparam logic [AW:0] LenOne   = (AW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q;
  logic [AW:0]         len_q;
  logic                pp_q;
  logic                err_q;
  logic [PE_COL-1:0]   wr_en_q;
  logic [8*PE_COL-1:0] din_q;
  logic [AW-1:0]       addr_q;

  logic start_acc;
  logic beat_acc;
  logic final_beat;
  logic tready;

  assign start_acc  = (state_q == StIdle) && start;
  assign beat_acc   = m_axis_mm2s.tvalid && tready;
  assign final_beat = ({1'b0, cnt_q} == (len_q - LenOne));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: zero or oversize lengths skip straight to DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if ((start_len == '0) || (start_len > DepthLen)) begin
            state_d = StDone;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        // An early tlast also terminates the load.
        if (beat_acc && (final_beat || m_axis_mm2s.tlast)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    tready = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        busy   = 1'b1;
        tready = 1'b1;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Beat counter, latched start parameters, sticky error and registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      len_q   <= '0;
      pp_q    <= 1'b0;
      err_q   <= 1'b0;
      wr_en_q <= '0;
      din_q   <= '0;
      addr_q  <= '0;
    end else begin
      wr_en_q <= '0;
      if (start_acc) begin
        cnt_q <= '0;
        len_q <= start_len;
        pp_q  <= start_pp;
        err_q <= (start_len > DepthLen);
      end else if (beat_acc) begin
        cnt_q   <= cnt_q + 1'b1;
        wr_en_q <= m_axis_mm2s.tkeep[PE_COL-1:0];
        din_q   <= m_axis_mm2s.tdata[8*PE_COL-1:0];
        addr_q  <= cnt_q;
        // Error when tlast disagrees with the expected final beat.
        if (final_beat != m_axis_mm2s.tlast) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign m_axis_mm2s.tready = tready;
  assign err                = err_q;
  assign load_fm_wr_en      = wr_en_q;
  assign load_fm_din        = din_q;
  assign load_fm_wr_addr    = {PE_COL{addr_q}};
  assign load_fm_ping_pong  = {PE_COL{pp_q}};

endmodule
